// File: rtl/sram_ext_pkg.sv
// sram_ext_pkg: shared state encoding, geometry derivation and parameter
// legality check for the banked SRAM controller and its tests.
package sram_ext_pkg;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  function automatic int calc_num_col(int bw_data, int bw_data_unit);
    return bw_data / bw_data_unit;
  endfunction

  function automatic int calc_num_row(int bw_addr, int bw_addr_unit);
    return 1 << (bw_addr - bw_addr_unit);
  endfunction

  function automatic bit params_ok(int bw_data, int bw_addr, int bw_data_unit, int bw_addr_unit);
    return bw_data_unit > 0 && bw_addr_unit > 0 && bw_data >= bw_data_unit &&
           bw_data % bw_data_unit == 0 && bw_addr >= bw_addr_unit;
  endfunction

endpackage

// File: rtl/spsram_unit.sv
// spsram_unit: BW_DATA_UNIT x 2^BW_ADDR_UNIT single-port synchronous SRAM.
//   i_cen enables an access, i_wen=1 writes i_data at i_addr, i_wen=0 reads
//   into the registered o_data, which holds until the next read.
module spsram_unit #(
  parameter int BW_DATA_UNIT = 64,
  parameter int BW_ADDR_UNIT = 6
) (
  input  logic                    i_clk,
  input  logic                    i_cen,
  input  logic                    i_wen,
  input  logic [BW_ADDR_UNIT-1:0] i_addr,
  input  logic [BW_DATA_UNIT-1:0] i_data,
  output logic [BW_DATA_UNIT-1:0] o_data
);
  logic [BW_DATA_UNIT-1:0] mem [2**BW_ADDR_UNIT];
  logic [BW_DATA_UNIT-1:0] rd_q;
  always_ff @(posedge i_clk) begin
    if (i_cen && i_wen) mem[i_addr] <= i_data;
    if (i_cen && !i_wen) rd_q <= mem[i_addr];
  end
  assign o_data = rd_q;
endmodule

// File: rtl/sram_bank_ctrl_param.sv
// sram_bank_ctrl_param: tiles NUM_ROW x NUM_COL spsram_unit macros into one
// BW_DATA x 2^BW_ADDR memory with req/ready handshake, per-column write mask,
// read-valid pipeline and a zero-fill sequencer after reset or on i_clr.
//   i_req/i_wen/i_addr/i_data/i_wmask : access request (accepted when o_ready & ~i_clr)
//   i_clr   : start a zero-fill (2^BW_ADDR_UNIT cycles, o_ready low)
//   o_valid : one-cycle pulse per read, o_data holds between pulses
// Optional macro SRAM_EXT_OUTREG_EN adds an output register (read latency 2).
module sram_bank_ctrl_param
  import sram_ext_pkg::*;
#(
  parameter int BW_DATA      = 256,
  parameter int BW_ADDR      = 10,
  parameter int BW_DATA_UNIT = 64,
  parameter int BW_ADDR_UNIT = 6
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic                                          i_req,
  input  logic                                          i_wen,
  input  logic [BW_ADDR-1:0]                            i_addr,
  input  logic [BW_DATA-1:0]                            i_data,
  input  logic [calc_num_col(BW_DATA, BW_DATA_UNIT)-1:0] i_wmask,
  input  logic                                          i_clr,
  output logic                                          o_ready,
  output logic                                          o_valid,
  output logic [BW_DATA-1:0]                            o_data
);
  localparam int NUM_COL = calc_num_col(BW_DATA, BW_DATA_UNIT);
  localparam int NUM_ROW = calc_num_row(BW_ADDR, BW_ADDR_UNIT);
  localparam int ROW_W = BW_ADDR > BW_ADDR_UNIT ? BW_ADDR - BW_ADDR_UNIT : 1;
  localparam logic [BW_ADDR_UNIT-1:0] CLR_LAST = '1;

  if (!params_ok(BW_DATA, BW_ADDR, BW_DATA_UNIT, BW_ADDR_UNIT)) begin : g_bad_params
    $error("sram_bank_ctrl_param: illegal parameter combination");
  end

  state_t                        state_q, state_d;
  logic [BW_ADDR_UNIT-1:0]       clr_cnt_q, clr_cnt_d;
  logic                          vld_q, vld_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic [BW_DATA-1:0]            cap_q, cap_d;
  logic                          init, acc;
  logic [ROW_W-1:0]              row;
  logic [NUM_ROW-1:0]            row_en;
  logic [BW_DATA-1:0]            mux_w;
  logic [NUM_ROW-1:0][BW_DATA-1:0] rd_w;

  always_comb begin
    init      = state_q == ST_INIT;
    acc       = i_req && state_q == ST_READY && !i_clr;
    row       = ROW_W'(i_addr >> BW_ADDR_UNIT);
    row_en    = acc ? NUM_ROW'(1) << row : '0;
    state_d   = i_clr ? ST_INIT : (init && clr_cnt_q == CLR_LAST) ? ST_READY : state_q;
    clr_cnt_d = (i_clr || !init) ? '0 : clr_cnt_q + 1'b1;
    vld_d     = acc && !i_wen;
    row_d     = acc ? row : row_q;
    mux_w     = rd_w[row_q];
    // unit outputs only change on reads, so the captured word survives a clear
    cap_d     = vld_q ? mux_w : cap_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      vld_q     <= 1'b0;
      row_q     <= '0;
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      vld_q     <= vld_d;
      row_q     <= row_d;
      cap_q     <= cap_d;
    end
  end

  // INIT drives every unit with a zero write at clr_cnt; otherwise only the
  // addressed row is enabled, and on writes only its unmasked columns.
  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      spsram_unit #(
        .BW_DATA_UNIT(BW_DATA_UNIT),
        .BW_ADDR_UNIT(BW_ADDR_UNIT)
      ) u_unit (
        .i_clk (i_clk),
        .i_cen (init || (row_en[r] && (!i_wen || i_wmask[c]))),
        .i_wen (init || i_wen),
        .i_addr(init ? clr_cnt_q : i_addr[BW_ADDR_UNIT-1:0]),
        .i_data(init ? {BW_DATA_UNIT{1'b0}} : i_data[c*BW_DATA_UNIT +: BW_DATA_UNIT]),
        .o_data(rd_w[r][c*BW_DATA_UNIT +: BW_DATA_UNIT])
      );
    end
  end

  assign o_ready = state_q == ST_READY;

`ifdef SRAM_EXT_OUTREG_EN
  logic vld2_q, vld2_d;
  always_comb vld2_d = vld_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) vld2_q <= 1'b0;
    else vld2_q <= vld2_d;
  end
  assign o_valid = vld2_q;
  assign o_data  = cap_q;
`else
  assign o_valid = vld_q;
  assign o_data  = vld_q ? mux_w : cap_q;
`endif

endmodule

// File: tb/tb_sram_bank_ctrl_param.sv
// tb_sram_bank_ctrl_param: directed + random stimulus against an array-based
// memory model with a latency-aligned expected-read queue.
module tb_sram_bank_ctrl_param;
  localparam int DEPTH = 1024;
  localparam int INIT_CYC = 64;
`ifdef SRAM_EXT_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst, req, wen, clr;
  logic [9:0]   addr;
  logic [255:0] data;
  logic [3:0]   wmask;
  logic         ready, valid;
  logic [255:0] dout;

  always #5 clk = ~clk;

  sram_bank_ctrl_param dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wen(wen), .i_addr(addr),
    .i_data(data), .i_wmask(wmask), .i_clr(clr),
    .o_ready(ready), .o_valid(valid), .o_data(dout)
  );

  logic [255:0] mem [DEPTH];
  int           init_left;
  bit           m_ready;
  bit           pv [LAT];
  logic [255:0] pd [LAT];
  logic [255:0] hold;
  int           n_vec = 0, n_err = 0;

  task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mem[i]) mem[i] = '0;
    init_left = INIT_CYC;
    m_ready = 0;
    for (int i = 0; i < LAT; i++) begin pv[i] = 0; pd[i] = '0; end
    hold = '0;
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = req && m_ready && !clr;
    for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
    pv[0] = acc && !wen;
    pd[0] = mem[addr];
    if (acc && wen)
      for (int k = 0; k < 4; k++) if (wmask[k]) mem[addr][k*64 +: 64] = data[k*64 +: 64];
    if (clr) begin
      init_left = INIT_CYC;
      m_ready = 0;
      foreach (mem[i]) mem[i] = '0;
    end else if (init_left > 0) begin
      init_left--;
      m_ready = init_left == 0;
    end
    if (pv[LAT-1]) hold = pd[LAT-1];
    #1;
    check("ready", 256'(ready), 256'(m_ready));
    check("valid", 256'(valid), 256'(pv[LAT-1]));
    check("data", dout, hold);
  endtask

  task automatic cyc(bit rq, bit w, logic [9:0] a, logic [255:0] d, logic [3:0] m, bit c);
    req = rq; wen = w; addr = a; data = d; wmask = m; clr = c;
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, '0, 0);
  endtask

  task automatic hard_reset();
    req = 0; wen = 0; clr = 0; addr = '0; data = '0; wmask = '0;
    rst = 1;
    #1;
    check("rst_ready", 256'(ready), 256'(0));
    check("rst_valid", 256'(valid), 256'(0));
    check("rst_data", dout, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_valid", 256'(valid), 256'(0));
    model_reset();
    rst = 0;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    hard_reset();
    idle(INIT_CYC);
    cyc(1, 0, 10'h3FF, '0, '0, 0);
    idle(LAT + 1);

    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 10'(i), {4{64'(i)}}, 4'hF, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 10'(i), '0, '0, 0);
    idle(LAT + 1);

    cyc(1, 1, 10'h001, '1, 4'b1111, 0);
    cyc(1, 1, 10'h001, '0, 4'b0101, 0);
    cyc(1, 0, 10'h001, '0, '0, 0);
    idle(LAT);
    check("mask_word", hold, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    cyc(1, 1, 10'h002, rnd256(), 4'b0000, 0);
    cyc(1, 0, 10'h002, '0, '0, 0);

    cyc(1, 1, 10'h03F, {4{64'hA5A5_0000_0000_003F}}, 4'hF, 0);
    cyc(1, 1, 10'h000, {4{64'h5A5A_0000_0000_0000}}, 4'hF, 0);
    cyc(1, 1, 10'h040, {4{64'hC3C3_0000_0000_0040}}, 4'hF, 0);
    cyc(1, 0, 10'h040, '0, '0, 0);
    cyc(1, 0, 10'h03F, '0, '0, 0);
    cyc(1, 0, 10'h000, '0, '0, 0);
    idle(LAT + 1);

    cyc(1, 1, 10'h155, {4{64'hDEAD_BEEF_0155_0155}}, 4'hF, 0);
    cyc(1, 0, 10'h155, '0, '0, 0);
    cyc(1, 0, 10'h155, '0, '0, 1);
    cyc(1, 0, 10'h155, '0, '0, 0);
    idle(INIT_CYC);
    cyc(1, 0, 10'h155, '0, '0, 0);
    idle(LAT + 1);

    rst = 1; hard_reset();
    idle(20);
    rst = 1; hard_reset();
    idle(INIT_CYC);
    cyc(1, 1, 10'h2AA, rnd256(), 4'hF, 0);
    cyc(1, 0, 10'h2AA, '0, '0, 0);
    hard_reset();
    idle(INIT_CYC);
    cyc(1, 0, 10'h2AA, '0, '0, 0);
    idle(LAT + 1);

    for (int n = 0; n < 4000; n++) begin
      logic [9:0] a;
      a = ($urandom % 2) ? 10'($urandom_range(0, 7) + 10'h03C) : 10'($urandom_range(0, DEPTH - 1));
      cyc(($urandom % 4) != 0, $urandom % 2, a, rnd256(), 4'($urandom), ($urandom % 300) == 0);
    end
    idle(LAT + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
